// File: rtl/washer_seq_pkg.sv
// Shared types for the washer cycle sequencer: state encoding and fault codes.
package washer_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FILL   = 4'd1,
        ST_WASH   = 4'd2,
        ST_DRAIN  = 4'd3,
        ST_SPIN   = 4'd4,
        ST_CDRAIN = 4'd5,
        ST_FAULT  = 4'd6
    } state_t;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_FILL_TO    = 3'd1;
    localparam logic [2:0] FC_DRAIN_TO   = 3'd2;
    localparam logic [2:0] FC_DOOR_LOCK  = 3'd3;
    localparam logic [2:0] FC_DOOR_START = 3'd4;

    // States in which the door is held locked and the sequence is considered running.
    function automatic logic is_locked(state_t s);
        return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) ||
               (s == ST_SPIN) || (s == ST_CDRAIN);
    endfunction

endpackage

// File: rtl/washer_timer.sv
// Phase timer: up-counter with synchronous clear, run enable and an equality compare.
module washer_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_eq
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TIMER_W'(1);
        end
    end

    assign o_eq = (r_cnt == i_limit);

endmodule

// File: rtl/washer_seq.sv
// Washer cycle sequencer: fill/wash/drain, rinse passes, spin, with pause,
// door lock, cancel-to-safe-drain and fault latching.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FILL   | fill valve open until water_full
//   WASH   | agitate for WASH_CYC active cycles
//   DRAIN  | pump out; loops to FILL while rinses remain, else SPIN
//   SPIN   | spin + pump until dry_sensor or SPIN_CYC
//   CDRAIN | cancel requested: pump out, then IDLE without done
//   FAULT  | everything off, code held until cancel
module washer_seq
    import washer_seq_pkg::*;
#(
    parameter int TIMER_W  = 16,
    parameter int RINSE_W  = 2,
    parameter int WASH_CYC = 1000,
    parameter int SPIN_CYC = 500,
    parameter int FILL_TO  = 4000,
    parameter int DRAIN_TO = 4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RINSE_W-1:0] rinse_cnt,
    input  logic               door_open,
    input  logic               water_full,
    input  logic               drained,
    input  logic               dry_sensor,
    input  logic               pause,
    input  logic               cancel,
    output logic               water_fill,
    output logic               motor_wash,
    output logic               motor_spin,
    output logic               drain,
    output logic               door_lock,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state
);

    localparam logic [TIMER_W-1:0] L_FILL  = TIMER_W'(FILL_TO - 1);
    localparam logic [TIMER_W-1:0] L_WASH  = TIMER_W'(WASH_CYC - 1);
    localparam logic [TIMER_W-1:0] L_SPIN  = TIMER_W'(SPIN_CYC - 1);
    localparam logic [TIMER_W-1:0] L_DRAIN = TIMER_W'(DRAIN_TO - 1);

    state_t             r_state;
    logic               r_pause;
    logic [2:0]         r_fc;
    logic               r_done;
    logic [RINSE_W-1:0] r_rinses;

    state_t             w_next;
    logic               w_locked;
    logic               w_run;
    logic               w_clr;
    logic               w_en;
    logic               w_eq;
    logic [TIMER_W-1:0] w_limit;
    logic               w_timeout;
    logic               w_fc_set;
    logic [2:0]         w_fc_val;

    assign w_locked = is_locked(r_state);
    assign w_run    = w_locked && !r_pause;
    assign w_clr    = (w_next != r_state);
    assign w_en     = w_run;

    washer_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_eq    (w_eq)
    );

    always_comb begin
        w_limit = L_WASH;
        case (r_state)
            ST_FILL:             w_limit = L_FILL;
            ST_SPIN:             w_limit = L_SPIN;
            ST_DRAIN, ST_CDRAIN: w_limit = L_DRAIN;
            default:             w_limit = L_WASH;
        endcase
    end

    // Timeouts only fire on a running cycle, so a paused phase cannot expire.
    assign w_timeout = w_run && w_eq &&
                       ((r_state == ST_FILL) || (r_state == ST_DRAIN) || (r_state == ST_CDRAIN));

    always_comb begin
        w_next   = r_state;
        w_fc_set = 1'b0;
        w_fc_val = FC_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (door_open) begin
                        w_next   = ST_FAULT;
                        w_fc_set = 1'b1;
                        w_fc_val = FC_DOOR_START;
                    end else begin
                        w_next = ST_FILL;
                    end
                end
            end
            ST_FAULT: begin
                if (cancel) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                if (door_open) begin
                    w_next   = ST_FAULT;
                    w_fc_set = 1'b1;
                    w_fc_val = FC_DOOR_LOCK;
                end else if (w_timeout) begin
                    w_next   = ST_FAULT;
                    w_fc_set = 1'b1;
                    w_fc_val = (r_state == ST_FILL) ? FC_FILL_TO : FC_DRAIN_TO;
                end else if (cancel && (r_state != ST_CDRAIN)) begin
                    w_next = ST_CDRAIN;
                end else if (!r_pause) begin
                    case (r_state)
                        ST_FILL:   if (water_full) w_next = ST_WASH;
                        ST_WASH:   if (w_eq) w_next = ST_DRAIN;
                        ST_DRAIN: begin
                            if (drained) begin
                                w_next = (r_rinses != '0) ? ST_FILL : ST_SPIN;
                            end
                        end
                        ST_SPIN:   if (dry_sensor || w_eq) w_next = ST_IDLE;
                        ST_CDRAIN: if (drained) w_next = ST_IDLE;
                        default:   w_next = r_state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pause  <= 1'b0;
            r_fc     <= FC_NONE;
            r_done   <= 1'b0;
            r_rinses <= '0;
        end else begin
            r_state <= w_next;
            r_pause <= pause;
            r_done  <= (r_state == ST_SPIN) && (w_next == ST_IDLE);
            if (w_fc_set) begin
                r_fc <= w_fc_val;
            end else if ((r_state == ST_FAULT) && (w_next == ST_IDLE)) begin
                r_fc <= FC_NONE;
            end
            if ((r_state == ST_IDLE) && (w_next == ST_FILL)) begin
                r_rinses <= rinse_cnt;
            end else if ((r_state == ST_DRAIN) && (w_next == ST_FILL)) begin
                r_rinses <= r_rinses - RINSE_W'(1);
            end
        end
    end

    assign water_fill = w_run && (r_state == ST_FILL);
    assign motor_wash = w_run && (r_state == ST_WASH);
    assign motor_spin = w_run && (r_state == ST_SPIN);
    assign drain      = w_run && ((r_state == ST_DRAIN) || (r_state == ST_SPIN) ||
                                  (r_state == ST_CDRAIN));
    assign door_lock  = w_locked;
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fc;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign done       = r_done;
    assign state      = r_state;

endmodule
